// File: rtl/keypad_emulator_if.sv
// ----------------------------------------------------------------------------
// keypad_emulator_if : column-drive / row-sense and key-queue signal bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface keypad_emulator_if #(
  parameter int DEPTH = 8
) ();
  localparam int c_cw = $clog2(DEPTH) + 1;

  logic [3:0]      col;
  logic            key_valid;
  logic [3:0]      key_code;
  logic            key_ready;
  logic            flush;
  logic [3:0]      row;
  logic            busy;
  logic            key_done;
  logic [c_cw-1:0] fifo_count;

  modport master (
    output col, key_valid, key_code, flush,
    input  key_ready, row, busy, key_done, fifo_count
  );

  modport slave (
    input  col, key_valid, key_code, flush,
    output key_ready, row, busy, key_done, fifo_count
  );
endinterface

`default_nettype wire

// File: rtl/keypad_emulator.sv
// ----------------------------------------------------------------------------
// keypad_emulator : 4x4 matrix-keypad model replaying queued key codes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module keypad_emulator #(
  parameter int DEPTH          = 8,
  parameter int PRESS_CYCLES   = 16,
  parameter int RELEASE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  keypad_emulator_if.slave   kp
);
  localparam int c_aw  = $clog2(DEPTH);
  localparam int c_cw  = c_aw + 1;
  localparam int c_max = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int c_tw  = (c_max > 1) ? $clog2(c_max) : 1;
  localparam logic [c_tw-1:0] c_press_ld = c_tw'(PRESS_CYCLES - 1);
  localparam logic [c_tw-1:0] c_rel_ld   = c_tw'(RELEASE_CYCLES - 1);
  localparam logic [c_cw-1:0] c_full     = c_cw'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESS   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_tw-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]      r_cur_key, w_cur_key_nxt;
  logic            r_key_done, w_done_nxt;
  logic [3:0]      r_row, w_row_nxt;

  logic [3:0]      r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_cw-1:0] r_count;
  logic            w_push, w_pop, w_empty, w_full;

  assign w_full  = (r_count == c_full);
  assign w_empty = (r_count == '0);
  // Push is gated on the pre-edge full flag, so a pop on the same edge never frees room
  assign w_push  = kp.key_valid && !w_full && !kp.flush;
  assign w_pop   = (r_state == S_IDLE) && !w_empty && !kp.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (kp.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= kp.key_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cur_key  <= '0;
      r_key_done <= 1'b0;
      r_row      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cur_key  <= w_cur_key_nxt;
      r_key_done <= w_done_nxt;
      r_row      <= w_row_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_cur_key_nxt = r_cur_key;
    w_done_nxt    = 1'b0;
    w_row_nxt     = 4'b0000;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_cur_key_nxt = r_mem[r_rd_ptr];
          w_cnt_nxt     = c_press_ld;
          w_state_nxt   = S_PRESS;
        end
      end
      S_PRESS: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = c_rel_ld;
          w_state_nxt = S_RELEASE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_RELEASE: begin
        if (r_cnt == '0) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Only an exact one-hot match on the key's column closes the switch
    if (r_state == S_PRESS && kp.col == (4'b1000 >> r_cur_key[1:0]))
      w_row_nxt = 4'b1000 >> r_cur_key[3:2];
    if (kp.flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_done_nxt  = 1'b0;
      w_row_nxt   = 4'b0000;
    end
  end

  assign kp.key_ready  = !w_full;
  assign kp.row        = r_row;
  assign kp.busy       = (r_state != S_IDLE) || !w_empty;
  assign kp.key_done   = r_key_done;
  assign kp.fifo_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_keypad_emulator.sv
// ----------------------------------------------------------------------------
// tb_keypad_emulator : directed self-checking bench for keypad_emulator
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_keypad_emulator;
  localparam int DEPTH = 8;
  localparam int PRESS = 16;
  localparam int REL   = 16;
  localparam int KP    = 1 + PRESS + REL;  // edges per key: pop + press + release

  logic clk = 1'b0;
  logic rst = 1'b1;

  keypad_emulator_if #(.DEPTH(DEPTH)) kp ();

  keypad_emulator #(
    .DEPTH(DEPTH), .PRESS_CYCLES(PRESS), .RELEASE_CYCLES(REL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         pop0     = 0;
  int         n_exp    = 0;
  logic [3:0] exp_keys [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic push(input logic [3:0] code);
    kp.key_valid = 1'b1;
    kp.key_code  = code;
    tick();
    kp.key_valid = 1'b0;
  endtask

  // Rotating column sweep; expected rows come from the hand-derived key schedule
  task automatic scan_run(input string tag, input int end_cyc, input int exp_done);
    logic [3:0] c, er;
    logic       ed;
    int         rel, ki, ph, dones;
    dones = 0;
    ph    = 0;
    while (cyc < end_cyc) begin
      c      = 4'b1000 >> ph[1:0];
      ph++;
      kp.col = c;
      tick();
      er  = 4'b0000;
      ed  = 1'b0;
      rel = cyc - pop0 - 1;
      if (rel >= 0) begin
        ki = rel / KP;
        if (ki < n_exp) begin
          if ((rel % KP) < PRESS && c == (4'b1000 >> exp_keys[ki][1:0]))
            er = 4'b1000 >> exp_keys[ki][3:2];
          if ((rel % KP) == KP - 2) ed = 1'b1;
        end
      end
      check({tag, "_row"}, kp.row, er);
      check({tag, "_done"}, kp.key_done, ed);
      if (kp.key_done) dones++;
    end
    check({tag, "_ndone"}, dones, exp_done);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] c;
    int         guard, d;
    kp.col       = 4'b0000;
    kp.key_valid = 1'b0;
    kp.key_code  = 4'b0000;
    kp.flush     = 1'b0;

    // 1: reset with sweeping columns
    for (int i = 0; i < 6; i++) begin
      c      = 4'b1000 >> (i % 4);
      kp.col = c;
      tick();
      check("t1_row", kp.row, 4'b0000);
      check("t1_ready", kp.key_ready, 1'b1);
      check("t1_busy", kp.busy, 1'b0);
      check("t1_count", kp.fifo_count, 0);
    end
    rst    = 1'b0;
    kp.col = 4'b0000;
    tick();

    // 2: single '8'
    pop0        = cyc + 2;
    n_exp       = 1;
    exp_keys[0] = 4'b1001;
    push(4'b1001);
    check("t2_count1", kp.fifo_count, 1);
    check("t2_busy1", kp.busy, 1'b1);
    scan_run("t2", pop0 + 1 + KP, 1);
    check("t2_busy_end", kp.busy, 1'b0);

    // 3: passcode 1,8,6,5 back-to-back
    kp.col      = 4'b0000;
    pop0        = cyc + 2;
    n_exp       = 4;
    exp_keys[0] = 4'b0000;
    exp_keys[1] = 4'b1001;
    exp_keys[2] = 4'b0110;
    exp_keys[3] = 4'b0101;
    for (int k = 0; k < 4; k++) push(exp_keys[k]);
    check("t3_count3", kp.fifo_count, 3);
    scan_run("t3a", pop0 + KP + 1, 1);
    check("t3_count2", kp.fifo_count, 2);
    scan_run("t3b", pop0 + 1 + 4 * KP, 3);
    check("t3_busy_end", kp.busy, 1'b0);
    check("t3_count_end", kp.fifo_count, 0);

    // 4: overfill while the first key is pressed
    kp.col      = 4'b0000;
    pop0        = cyc + 2;
    exp_keys[0] = 4'h3;
    push(4'h3);
    tick();
    for (int k = 1; k <= 8; k++) begin
      exp_keys[k] = 4'(k + 3);
      push(exp_keys[k]);
    end
    check("t4_count_full", kp.fifo_count, 8);
    check("t4_ready_low", kp.key_ready, 1'b0);
    exp_keys[9]  = 4'hE;
    n_exp        = 10;
    kp.key_valid = 1'b1;
    kp.key_code  = 4'hE;
    tick();
    check("t4_count_hold", kp.fifo_count, 8);
    guard = 0;
    while (kp.key_ready == 1'b0 && guard < 100) begin
      tick();
      guard++;
    end
    check("t4_ready_cyc", cyc, pop0 + KP);
    check("t4_count_popped", kp.fifo_count, 7);
    tick();
    kp.key_valid = 1'b0;
    check("t4_count_refill", kp.fifo_count, 8);
    scan_run("t4", pop0 + 1 + 10 * KP, 9);
    check("t4_busy_end", kp.busy, 1'b0);
    check("t4_count_end", kp.fifo_count, 0);

    // 5: flush mid-PRESS with three queued
    kp.col = 4'b0000;
    push(4'b0101);
    push(4'b0000);
    push(4'b1001);
    push(4'b0110);
    check("t5_count3", kp.fifo_count, 3);
    kp.col = 4'b0100;
    tick();
    check("t5_row_pre", kp.row, 4'b0100);
    kp.flush     = 1'b1;
    kp.key_valid = 1'b1;
    kp.key_code  = 4'h7;
    tick();
    kp.flush     = 1'b0;
    kp.key_valid = 1'b0;
    check("t5_row_flush", kp.row, 4'b0000);
    check("t5_count_flush", kp.fifo_count, 0);
    check("t5_busy_flush", kp.busy, 1'b0);
    d = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (kp.key_done) d++;
      check("t5_row_after", kp.row, 4'b0000);
    end
    check("t5_ndone", d, 0);

    // 6: bad column patterns, then async reset mid-PRESS
    kp.col = 4'b0000;
    push(4'b0110);
    kp.col = 4'b0010;
    tick();
    tick();
    check("t6_row_match", kp.row, 4'b0100);
    kp.col = 4'b0000;
    tick();
    check("t6_row_col0", kp.row, 4'b0000);
    kp.col = 4'b1100;
    tick();
    check("t6_row_col1100", kp.row, 4'b0000);
    kp.col = 4'b0010;
    tick();
    check("t6_row_rematch", kp.row, 4'b0100);
    push(4'b1111);
    check("t6_count1", kp.fifo_count, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_row_async", kp.row, 4'b0000);
    check("t6_count_async", kp.fifo_count, 0);
    check("t6_busy_async", kp.busy, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("t6_row_post", kp.row, 4'b0000);
    check("t6_busy_post", kp.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
